// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: multi-digit packed-BCD adder/subtractor.
// A single shared digit adder walks the operands one digit per clock,
// least-significant digit first. Carry/borrow in and out allow chaining.
// Subtraction is done as a + (9's complement of b) + (~borrow), so a
// borrow-out leaves the ten's-complement result in sum.

module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] a_reg;
  logic [4*DIGITS-1:0] b_reg;
  logic                sub_reg;
  logic                carry;
  logic [IDX_W-1:0]    idx;

  logic [3:0]          a_dig;
  logic [3:0]          b_dig;
  logic [3:0]          b_eff;
  logic [4:0]          dsum;
  logic [3:0]          digit;
  logic                carry_next;
  logic                bad_digit;

  // Shared digit adder: picks digit idx of the latched operands, applies the
  // 9's complement to b when subtracting, and applies decimal correction.
  always_comb begin
    a_dig      = a_reg[{idx, 2'b00} +: 4];
    b_dig      = b_reg[{idx, 2'b00} +: 4];
    b_eff      = sub_reg ? (4'd9 - b_dig) : b_dig;
    dsum       = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
    digit      = dsum[3:0];
    carry_next = 1'b0;
    if (dsum > 5'd9) begin
      digit      = dsum[3:0] + 4'd6;
      carry_next = 1'b1;
    end
  end

  // Any digit above 9 in either latched operand marks the result invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((a_reg[4*k +: 4] > 4'd9) || (b_reg[4*k +: 4] > 4'd9)) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            carry   <= sub ? ~cin : cin;
            idx     <= '0;
            sum     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= digit;
          carry                  <= carry_next;
          if (idx == LAST_IDX) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            cout    <= sub_reg ? ~carry_next : carry_next;
            invalid <= bad_digit;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
Parametrised multi-digit packed-BCD adder/subtractor.
- Processes one BCD digit per clock, least-significant digit first, through a single shared digit adder with decimal correction.
- Start/busy/done handshake.
- Carry/borrow in and out, so instances chain for wider words.
- Flags non-BCD input digits.
- Sits between keypad/register-file BCD operands and the 7-segment display path.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a new operation; sampled only when busy=0.
- sub  input  1  0 = a+b+cin; 1 = a-b-cin. Latched with start.
- cin  input  1  carry-in (add) or borrow-in (sub). Latched with start.
- a  input  4*DIGITS  packed BCD operand A, digit 0 in [3:0]. Latched with start.
- b  input  4*DIGITS  packed BCD operand B. Latched with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; sum/cout/invalid valid from this cycle on.
- sum  output  4*DIGITS  packed BCD result.
- cout  output  1  carry-out (add) or borrow-out (sub).
- invalid  output  1  at least one digit of a or b was >9.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, invalid=0.
  - Digit index, carry and operand registers cleared; any operation in progress is abandoned with no done.
- States: IDLE, RUN, DONE.
  - IDLE or DONE, start=1 at edge E:
    - latch a, b, sub, cin;
    - clear the sum register;
    - set digit index=0;
    - set carry = sub ? ~cin : cin;
    - go to RUN (busy=1 after E).
  - IDLE or DONE, start=0: DONE goes to IDLE; IDLE stays.
  - RUN, each edge processes digit k (k=0..DIGITS-1) and writes it into sum digit k.
    - After the edge processing digit DIGITS-1, i.e. edge E+DIGITS, go to DONE.
    - Result: busy=0, done=1 for exactly one cycle, cout and invalid updated.
  - start while busy=1 is ignored; latched operands are unaffected.
  - Back-to-back: start in the DONE cycle begins a new operation at that edge; done deasserts.
- Latency: done is high in the cycle after edge E+DIGITS. Throughput: one operation per DIGITS+1 cycles.
- Digit arithmetic, with bd = sub ? (9 - b_k) mod 16 : b_k:
  - s = a_k + bd + carry, 5-bit unsigned.
  - If s > 9: digit = (s + 6)[3:0], carry_next = 1.
  - Else: digit = s[3:0], carry_next = 0.
- Final outputs:
  - cout = sub ? ~carry_final : carry_final.
  - Sub with borrow: sum is the ten's complement (10^DIGITS + a - b - cin). No sign-magnitude conversion.
- sum, cout and invalid hold their values from done until the next accepted start or reset.
  - sum digits are written progressively during RUN; they are only valid at or after done.
- invalid:
  - Computed from the latched operands: any a_k > 9 or any b_k > 9.
  - Arithmetic still follows the rule above; the result is defined but not meaningful.
- DIGITS=1: RUN lasts one cycle; behaviour is otherwise identical.

Test Plan (DIGITS=4):
- Add 1234 + 5678, cin=0, start for one cycle → busy for 4 cycles; done in the 5th cycle after the start edge; sum=6912, cout=0, invalid=0.
- Add 9999 + 0000, cin=1 → sum=0000, cout=1. Add 0999 + 0001, cin=0 → sum=1000, cout=0 (carry ripples across 3 digits).
- Sub 5000 - 1234, cin=0 → sum=3766, cout=0. Sub 1234 - 5000, cin=0 → sum=6234, cout=1. Sub 0000 - 0000, cin=1 → sum=9999, cout=1.
- a=0x00A1, b=0x0001, add → done, invalid=1. Next op 0001 + 0001 → invalid=0, sum=0002.
- Start held high continuously with 0005 + 0005 → new op accepted every 5 cycles; each done shows sum=0010. Changing a/b while busy does not alter the result.
- rst pulsed asynchronously (between edges) at digit 2 of 1234 + 5678 → all outputs 0 immediately; no done. A following 0001 + 0002 gives 0003.
